// File: rtl/seg_pkg.sv
// Shared constants and the leading-zero suppression helper for the 7-segment scan block.
package seg_pkg;
  localparam int          SEG_DIGITS = 4;
  localparam logic [3:0]  AN_ALL_OFF = 4'b1111;
  localparam logic        DP_OFF     = 1'b1;

  // Bit i set means digit i and every digit above it hold zero; digit 0 is never masked.
  function automatic logic [SEG_DIGITS-1:0] lz_mask(input logic [15:0] value16);
    logic [SEG_DIGITS-1:0] m;
    logic                  zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = SEG_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (value16[i*4 +: 4] == 4'h0);
      m[i]       = zero_above;
    end
    return m;
  endfunction
endpackage

// File: rtl/seg_scan4_if.sv
// Display-side bundle: live value/controls towards the scanner, scanned digit outputs back.
interface seg_scan4_if;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic        lz_suppress;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic        frame_start;

  modport master (output value, dp_in, digit_en, lz_suppress,
                  input  nibble, an, dp, frame_start);
  modport slave  (input  value, dp_in, digit_en, lz_suppress,
                  output nibble, an, dp, frame_start);
endinterface

// File: rtl/seg_tick_gen.sv
// Slot prescaler: counts 0..CLK_DIV-1, flags the last cycle of each slot.
module seg_tick_gen #(
  parameter int CLK_DIV = 100000,
  localparam int TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic          clk,
  input  logic          reset,
  output logic [TW-1:0] tick_o,
  output logic          slot_end_o
);
  logic [TW-1:0] tick_q, tick_d;

  assign slot_end_o = (tick_q == TW'(CLK_DIV - 1));
  assign tick_o     = tick_q;

  always_comb begin
    tick_d = slot_end_o ? '0 : tick_q + TW'(1);
  end

  // Reset parks on the last tick so the first released edge is a frame boundary.
  always_ff @(posedge clk) begin
    if (reset) tick_q <= TW'(CLK_DIV - 1);
    else       tick_q <= tick_d;
  end
endmodule

// File: rtl/seg_scan4.sv
// Four-digit multiplexed scan controller: snapshots inputs per frame, blanks anodes at slot start.
module seg_scan4
  import seg_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 16,
  localparam int TW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic        clk,
  input  logic        reset,
  seg_scan4_if.slave  bus
);
  logic [TW-1:0] tick;
  logic          slot_end;

  seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk),
    .reset      (reset),
    .tick_o     (tick),
    .slot_end_o (slot_end)
  );

  logic [1:0]  idx_q, idx_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  en_q, en_d;
  logic        lz_q, lz_d;
  logic        fs_q, fs_d;
  logic        frame_edge;

  assign frame_edge = slot_end && (idx_q == 2'd3);

  always_comb begin
    idx_d   = slot_end ? idx_q + 2'd1 : idx_q;
    value_d = value_q;
    dp_d    = dp_q;
    en_d    = en_q;
    lz_d    = lz_q;
    fs_d    = frame_edge;
    if (frame_edge) begin
      value_d = bus.value;
      dp_d    = bus.dp_in;
      en_d    = bus.digit_en;
      lz_d    = bus.lz_suppress;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd3;
      value_q <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      lz_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      value_q <= value_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      lz_q    <= lz_d;
      fs_q    <= fs_d;
    end
  end

  // Output decode looks only at registered state, never at the live inputs.
  logic [SEG_DIGITS-1:0] sup_mask;
  logic                  visible;
  logic                  blanking;
  logic [3:0]            an_c;
  logic                  dp_c;

  assign sup_mask = lz_mask(value_q);
  assign visible  = en_q[idx_q] && !(lz_q && sup_mask[idx_q]);
  assign blanking = (32'(tick) < BLANK_CYCLES);

  always_comb begin
    an_c = AN_ALL_OFF;
    if (!blanking && visible) an_c[idx_q] = 1'b0;
    dp_c = (!an_c[idx_q] && dp_q[idx_q]) ? 1'b0 : DP_OFF;
  end

  assign bus.nibble      = value_q[idx_q*4 +: 4];
  assign bus.an          = an_c;
  assign bus.dp          = dp_c;
  assign bus.frame_start = fs_q;
endmodule

// File: doc/seg_scan4.md
# seg_scan4

Four-digit time-multiplexed scan controller for the board's common-anode 7-segment display. It sits directly upstream of the hex-to-segment decoder. Each cycle it presents one 4-bit nibble for the decoder to convert, and drives the matching active-low anode and decimal point. A per-frame snapshot of the inputs prevents digit tearing, and a dead-time at each digit switch suppresses ghosting.

## Interface
- `CLK_DIV`, default 100000: clock cycles per digit slot. Must be ≥ 2. At 100 MHz this gives a 1 kHz slot rate and a 250 Hz frame rate.
- `BLANK_CYCLES`, default 16: all-anodes-off cycles at the start of each slot. Must satisfy 0 ≤ `BLANK_CYCLES` < `CLK_DIV`.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  16  display value; `[3:0]` = digit 0 (rightmost) … `[15:12]` = digit 3.
- `dp_in`  in  4  decimal point request per digit; 1 = lit.
- `digit_en`  in  4  per-digit enable; 0 = digit forced blank.
- `lz_suppress`  in  1  leading-zero suppression enable.
- `nibble`  out  4  hex value of the current slot's digit, fed to the decoder.
- `an`  out  4  anode enables, active-low; `an[i]` drives digit i.
- `dp`  out  1  decimal point, active-low.
- `frame_start`  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- **State:** slot counter `tick` (0..`CLK_DIV`-1), digit index `idx` (0..3), and shadow registers for `value`, `dp_in`, `digit_en` and `lz_suppress`.
- **Counting:** `tick` increments every cycle.
  - When `tick` = `CLK_DIV`-1, `tick` wraps to 0 and `idx` advances 0→1→2→3→0.
- **Frame boundary edge:** the edge at which `idx`=3 and `tick`=`CLK_DIV`-1. On that edge:
  - the shadow registers load the live inputs;
  - `frame_start` registers to 1 for exactly one cycle, coinciding with `idx`=0, `tick`=0.
- **Visibility:** digit i is visible iff shadow `digit_en[i]`=1 and it is not suppressed.
  - Suppression requires shadow `lz_suppress`=1, i ≠ 0, and shadow nibbles i..3 all zero.
  - Digit 0 is never suppressed.
- **Output decode:** outputs decode from registered state only; there is no combinational path from any input to any output.
  - `nibble` = shadow nibble[`idx`], always, including during blanking.
  - `an` = 4'b1111 if `tick` < `BLANK_CYCLES` or digit `idx` is not visible. Otherwise `an[idx]`=0 and all other bits are 1.
  - `dp` = 0 iff `an[idx]`=0 and shadow `dp_in[idx]`=1; otherwise 1.
- **Live input changes:** changes to any live input between frame boundaries have no visible effect until the next boundary.

## Timing
- **Reset values:** `tick`=`CLK_DIV`-1, `idx`=3, all shadows 0, `frame_start`=0. This yields `an`=4'b1111, `dp`=1, `nibble`=0 while reset is held.
- **Reset release:** the first edge with `reset` low is a frame boundary. `frame_start`=1 in the following cycle, and digit 0 appears after `BLANK_CYCLES` further cycles.
- **Reset mid-frame:** outputs blank in the cycle after the reset edge; the next frame restarts from the reset state above.
- **Periods:**
  - slot = `CLK_DIV` cycles;
  - frame = 4·`CLK_DIV` cycles;
  - `frame_start` period = 4·`CLK_DIV`.
- **Anode duty:** each visible digit has its anode low for `CLK_DIV`-`BLANK_CYCLES` consecutive cycles per frame.
- **Anode exclusivity:** never more than one `an` bit is low in any cycle.
- **Zero blanking:** with `BLANK_CYCLES`=0, anodes switch directly between digits on the slot edge with no dead cycle.

## Structure
- **Shared package `seg_pkg`:**
  - `SEG_DIGITS`=4;
  - `AN_ALL_OFF`=4'b1111;
  - `DP_OFF`=1'b1;
  - a function `lz_mask(value16)` returning the 4-bit suppression mask.
- **Sub-module `seg_tick_gen`:** the `tick` prescaler.
  - Parameter `CLK_DIV`.
  - Outputs `tick` and `slot_end` (high when `tick`=`CLK_DIV`-1).
- **Integration:** the decoder is instantiated by the top level, not inside this block.

## Test plan
All scenarios use `CLK_DIV`=8 and `BLANK_CYCLES`=2.
- **Reset held, then released:** while held, `an`=1111, `dp`=1, `nibble`=0, `frame_start`=0. After release, `frame_start`=1 one cycle later; 2 cycles after that, `an`=1110 and `nibble`=shadow `value[3:0]`.
- **Scan order:** `value`=16'h1A2F, `digit_en`=1111. Slot cycles 2–7 show `an`=1110/`nibble`=F, then 1101/2, then 1011/A, then 0111/1. Cycles 0–1 of every slot show `an`=1111. `frame_start` repeats every 32 cycles.
- **Snapshot:** change `value` from 16'h1111 to 16'h2222 during slot 1. `nibble` stays 1 for slots 1–3, then shows 2 from the next `frame_start`.
- **Leading-zero suppression:** `lz_suppress`=1.
  - `value`=16'h0050: slots 3 and 2 keep `an`=1111; slot 1 shows 5; slot 0 shows 0.
  - `value`=16'h0000: only `an`=1110 is ever asserted.
- **Decimal point:** `dp_in`=0101, `digit_en`=1011. `dp`=0 only in slot 0 cycles 2–7; slot 2 stays blank with `dp`=1.
- **Reset mid-frame:** pulse `reset` during slot 2. `an`=1111 the next cycle; the frame restarts, with the first `frame_start` one cycle after release.
